// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the 4-bit carry-lookahead adder slice.
//   CLA_WIDTH  : operand width, fixed at 4
//   cla_word_t : one operand word
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    typedef logic [CLA_WIDTH-1:0] cla_word_t;

endpackage : cla_pkg

// File: rtl/cla_logic_4.sv
// -----------------------------------------------------------------------------
// cla_logic_4
// Purely combinational 4-bit carry-lookahead core. Every carry is written in
// flattened sum-of-products form, so no carry depends on another carry.
// Ports:
//   a, b     in  4  operands
//   carryin  in  1  carry into bit 0
//   sum      out 4  sum bits
//   c4       out 1  carry out of bit 3
//   c3       out 1  carry into bit 3 (used for signed overflow)
//   group_p  out 1  group propagate
//   group_g  out 1  group generate, independent of carryin
// -----------------------------------------------------------------------------
module cla_logic_4
    import cla_pkg::*;
(
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 carryin,
    output logic [CLA_WIDTH-1:0] sum,
    output logic                 c4,
    output logic                 c3,
    output logic                 group_p,
    output logic                 group_g
);

    cla_word_t p;
    cla_word_t g;
    cla_word_t c;

    // Per-bit propagate and generate terms.
    assign p = a ^ b;
    assign g = a & b;

    // Two-level lookahead: each carry is expanded all the way back to carryin.
    always_comb begin
        c[0] = carryin;
        c[1] = g[0] | (p[0] & carryin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carryin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & carryin);
    end

    assign c3 = c[3];

    // group_g deliberately omits carryin so a higher-level lookahead unit can
    // combine it with its own incoming carry.
    assign group_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
    assign group_p = &p;

    assign c4  = group_g | (group_p & carryin);
    assign sum = p ^ c;

endmodule : cla_logic_4

// File: rtl/four_bit_cla_adder.sv
// -----------------------------------------------------------------------------
// four_bit_cla_adder
// Registered 4-bit carry-lookahead adder. Results appear one clock after an
// input qualified by in_valid; results hold while in_valid is low.
// Optional feature macro: FOUR_BIT_CLA_ADDER_OVERFLOW_EN adds a registered
// signed-overflow output.
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  asynchronous active-low reset
//   in_valid   in  1  qualifies a, b, carryin
//   a, b       in  4  operands
//   carryin    in  1  carry into bit 0
//   sum        out 4  registered sum
//   carryout   out 1  registered carry out
//   group_p    out 1  registered group propagate
//   group_g    out 1  registered group generate
//   overflow   out 1  registered signed overflow (macro only)
//   out_valid  out 1  one-cycle pulse per accepted input
// -----------------------------------------------------------------------------
module four_bit_cla_adder
    import cla_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 carryin,
    output logic [CLA_WIDTH-1:0] sum,
    output logic                 carryout,
    output logic                 group_p,
    output logic                 group_g,
`ifdef FOUR_BIT_CLA_ADDER_OVERFLOW_EN
    output logic                 overflow,
`endif
    output logic                 out_valid
);

    cla_word_t sumComb;
    logic      c4Comb;
    logic      c3Comb;
    logic      groupPComb;
    logic      groupGComb;

    cla_word_t sum_q,      sum_d;
    logic      carryout_q, carryout_d;
    logic      group_p_q,  group_p_d;
    logic      group_g_q,  group_g_d;
    logic      valid_q,    valid_d;

    cla_logic_4 u_logic (
        .a       (a),
        .b       (b),
        .carryin (carryin),
        .sum     (sumComb),
        .c4      (c4Comb),
        .c3      (c3Comb),
        .group_p (groupPComb),
        .group_g (groupGComb)
    );

    // Next-state: load fresh results only when qualified, otherwise hold.
    always_comb begin
        sum_d      = sum_q;
        carryout_d = carryout_q;
        group_p_d  = group_p_q;
        group_g_d  = group_g_q;
        valid_d    = in_valid;
        if (in_valid) begin
            sum_d      = sumComb;
            carryout_d = c4Comb;
            group_p_d  = groupPComb;
            group_g_d  = groupGComb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carryout_q <= 1'b0;
            group_p_q  <= 1'b0;
            group_g_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            carryout_q <= carryout_d;
            group_p_q  <= group_p_d;
            group_g_q  <= group_g_d;
            valid_q    <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign carryout  = carryout_q;
    assign group_p   = group_p_q;
    assign group_g   = group_g_q;
    assign out_valid = valid_q;

`ifdef FOUR_BIT_CLA_ADDER_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // Two's-complement overflow: carry into the sign bit differs from carry out.
    always_comb begin
        overflow_d = overflow_q;
        if (in_valid) begin
            overflow_d = c4Comb ^ c3Comb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unusedC3;
    assign unusedC3 = c3Comb;
`endif

endmodule : four_bit_cla_adder

// File: tb/tb_four_bit_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_four_bit_cla_adder
// Scoreboard bench for four_bit_cla_adder: expected results are queued when an
// input is driven and popped when the DUT reports out_valid; idle cycles check
// that outputs hold the last result.
// -----------------------------------------------------------------------------
module tb_four_bit_cla_adder;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       gp;
        logic       gg;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       inValid;
    logic [3:0] aIn;
    logic [3:0] bIn;
    logic       cIn;
    logic [3:0] sum;
    logic       carryout;
    logic       groupP;
    logic       groupG;
    logic       outValid;
`ifdef FOUR_BIT_CLA_ADDER_OVERFLOW_EN
    logic       overflow;
`endif

    exp_t expQ[$];
    exp_t lastExp;
    bit   monEn;
    int   testsRun;
    int   failCount;

    four_bit_cla_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .a         (aIn),
        .b         (bIn),
        .carryin   (cIn),
        .sum       (sum),
        .carryout  (carryout),
        .group_p   (groupP),
        .group_g   (groupG),
`ifdef FOUR_BIT_CLA_ADDER_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .out_valid (outValid)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from integer arithmetic, not from the lookahead equations.
    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic ci);
        exp_t e;
        logic [4:0] total;
        logic [4:0] noCarry;
        total   = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        noCarry = {1'b0, x} + {1'b0, y};
        e.sum   = total[3:0];
        e.cout  = total[4];
        e.gp    = ((x ^ y) == 4'hF);
        e.gg    = noCarry[4];
        e.ov    = (x[3] == y[3]) && (total[3] != x[3]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic ci);
        @(negedge clk);
        aIn     = x;
        bIn     = y;
        cIn     = ci;
        inValid = 1'b1;
        expQ.push_back(model(x, y, ci));
    endtask

    // Idle cycles scramble the operands so a hold failure cannot hide behind stale inputs.
    task automatic applyIdle(input int n);
        repeat (n) begin
            @(negedge clk);
            inValid = 1'b0;
            aIn     = 4'($urandom);
            bIn     = 4'($urandom);
            cIn     = 1'($urandom);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_sum"}, {4'b0, sum}, 8'h00);
        checkOutput({tag, "_cout"}, {7'b0, carryout}, 8'h00);
        checkOutput({tag, "_gp"}, {7'b0, groupP}, 8'h00);
        checkOutput({tag, "_gg"}, {7'b0, groupG}, 8'h00);
        checkOutput({tag, "_valid"}, {7'b0, outValid}, 8'h00);
`ifdef FOUR_BIT_CLA_ADDER_OVERFLOW_EN
        checkOutput({tag, "_ov"}, {7'b0, overflow}, 8'h00);
`endif
    endtask

    // Monitor: one result per edge while enabled; with nothing pending the
    // outputs must still show the previous result.
    always @(posedge clk) begin
        #1;
        if (monEn) begin
            checkOutput("out_valid", {7'b0, outValid}, {7'b0, (expQ.size() > 0)});
            if (expQ.size() > 0) begin
                lastExp = expQ.pop_front();
            end
            checkOutput("sum", {4'b0, sum}, {4'b0, lastExp.sum});
            checkOutput("carryout", {7'b0, carryout}, {7'b0, lastExp.cout});
            checkOutput("group_p", {7'b0, groupP}, {7'b0, lastExp.gp});
            checkOutput("group_g", {7'b0, groupG}, {7'b0, lastExp.gg});
`ifdef FOUR_BIT_CLA_ADDER_OVERFLOW_EN
            checkOutput("overflow", {7'b0, overflow}, {7'b0, lastExp.ov});
`endif
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        testsRun  = 0;
        failCount = 0;
        monEn     = 1'b0;
        lastExp   = '0;
        inValid   = 1'b0;
        aIn       = 4'h0;
        bIn       = 4'h0;
        cIn       = 1'b0;
        rst_n     = 1'b1;

        // Reset: outputs clear immediately and ignore in_valid while held.
        #1 rst_n = 1'b0;
        #1 checkAllZero("reset");
        inValid = 1'b1;
        aIn     = 4'hF;
        bIn     = 4'hF;
        cIn     = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkAllZero("reset_hold");
        @(negedge clk);
        inValid = 1'b0;
        rst_n   = 1'b1;
        monEn   = 1'b1;

        // Directed cases, including full propagate chain and saturation.
        applyStimulus(4'b0111, 4'b0111, 1'b0);
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        applyStimulus(4'b1010, 4'b0101, 1'b1);
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        applyIdle(4);

        // Every operand/carry combination streamed back-to-back.
        for (int i = 0; i < 512; i++) begin
            applyStimulus(i[3:0], i[7:4], i[8]);
        end
        applyIdle(3);

        // Reset asserted between edges while out_valid is high.
        applyStimulus(4'b0110, 4'b0101, 1'b1);
        @(posedge clk);
        #3;
        monEn = 1'b0;
        rst_n = 1'b0;
        #1 checkAllZero("midreset");
        @(posedge clk);
        #1 checkAllZero("midreset_hold");
        @(negedge clk);
        expQ.delete();
        lastExp = '0;
        inValid = 1'b0;
        rst_n   = 1'b1;
        monEn   = 1'b1;
        applyIdle(2);

        // First edge after release samples normally.
        applyStimulus(4'b1001, 4'b1001, 1'b0);
        applyStimulus(4'b0011, 4'b0100, 1'b1);
        applyIdle(3);

        monEn = 1'b0;
        checkOutput("scoreboard_drain", 8'(expQ.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule : tb_four_bit_cla_adder

// File: doc/four_bit_cla_adder.md
# four_bit_cla_adder

Registered 4-bit carry-lookahead adder: adds two 4-bit operands plus a carry-in through a two-level lookahead carry network, with the result captured in output registers one clock after a qualified input. It is a leaf arithmetic cell for wider adders and datapath ALUs. It also exports group propagate/generate so several instances can be cascaded under a higher-level lookahead unit.

## Interface
- Parameters: none. Width is fixed at 4 through the package constant `CLA_WIDTH`.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  qualifies `a`, `b`, `carryin` this cycle.
- `a`  input  4  operand A.
- `b`  input  4  operand B.
- `carryin`  input  1  carry into bit 0.
- `sum`  output  4  registered sum bits.
- `carryout`  output  1  registered carry out of bit 3.
- `group_p`  output  1  registered group propagate, p0&p1&p2&p3.
- `group_g`  output  1  registered group generate.
- `out_valid`  output  1  registered; high for one cycle per accepted input.
- `overflow`  output  1  registered signed overflow. Present only with `FOUR_BIT_CLA_ADDER_OVERFLOW_EN`.

## Operation
- Per bit: p[i] = a[i]^b[i] and g[i] = a[i]&b[i].
- Carries are computed in flattened lookahead form, with no ripple chain:
  - c0 = carryin
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
- sum[i] = p[i] ^ c[i]; carryout = c4.
- group_g = g3 | p3g2 | p3p2g1 | p3p2p1g0. It is independent of carryin.
- group_p = &p.
- Arithmetic: {carryout, sum} equals the 5-bit value a + b + carryin. The operands are treated as unsigned, modulo 32.
- Each accepted input is fully independent. No carry or state passes between transactions.
- X/Z on inputs is not sanitised. Garbage in produces garbage out, and only when in_valid is high.

## Timing
- On reset assertion, all outputs go to 0 immediately: sum, carryout, group_p, group_g, out_valid and overflow.
- While rst_n is low, outputs stay at 0 and in_valid is ignored.
- Latency is 1 cycle. Inputs sampled at edge N with in_valid=1 appear on outputs after edge N, and out_valid=1 for that cycle.
- When in_valid=0 at an edge:
  - out_valid drops to 0.
  - sum, carryout, group_p, group_g and overflow hold their last values.
- Back-to-back valid inputs give one result per cycle. There is no backpressure and no ready signal.
- Reset deasserting mid-stream: the first edge after release samples normally. No result from before reset is reproduced.
- Combinational path: a/b/carryin to register D inputs only. No output is combinational.

## Configuration
- `FOUR_BIT_CLA_ADDER_OVERFLOW_EN` defined:
  - Adds port `overflow`, registered with the rest of the outputs.
  - overflow = c4 ^ c3 (two's-complement overflow).
  - Resets to 0 and holds when in_valid=0.
- Macro undefined: the `overflow` port and its register do not exist. All other behaviour is identical.

## Structure
- Package `cla_pkg` holds:
  - `CLA_WIDTH` = 4.
  - A typedef for the 4-bit operand (`cla_word_t`).
- One combinational sub-module, `cla_logic_4`:
  - Inputs: a, b, carryin.
  - Outputs: sum, c4, c3, group_p, group_g.
  - It contains all p/g and lookahead equations.
- The top level adds the input qualification and output registers only.

## Test plan
- Reset, then apply a=0111, b=0111, carryin=0 with in_valid -> next cycle sum=1110, carryout=0, group_p=0, group_g=0, out_valid=1. With the macro: overflow=1.
- a=1111, b=0001, carryin=0 -> sum=0000, carryout=1, group_g=1, group_p=0, overflow=0.
- a=1010, b=0101, carryin=1 -> sum=0000, carryout=1, group_p=1, group_g=0. This exercises the full propagate chain.
- a=1111, b=1111, carryin=1 -> sum=1111, carryout=1. Then hold in_valid=0 for 3 cycles -> out_valid=0 and values held.
- Exhaustive: all 512 combinations streamed back-to-back -> each result matches a+b+carryin one cycle later.
- Assert rst_n low mid-stream while out_valid=1 -> all outputs 0 immediately, before the next clock edge.
